// File: rtl/trafficsample_readout.sv
// Traffic-sample FIFO with a 16-bit valid/ready serializer (high half first).
// Define TRAFFICSAMPLE_OVFL_REPORT_EN to prefix samples with FFFF/count marker words after drops.
module trafficsample_readout #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sample_wr,
    input  logic [31:0]              sample_data,
    output logic [15:0]              out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_marker,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic [15:0]              overflow_cnt
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, HI, LO, MARK, MCNT} state_t;

    state_t      state, state_d;
    logic [31:0] mem [DEPTH];
    logic [AW:0] wptr, rptr, count, rptr_n;
    logic [31:0] head_n;
    logic        full, empty, hs, pop, drop, push;
    logic        go_mark, mcnt_clr;
    logic [15:0] data_d;
    logic        valid_d, marker_d;

    assign count      = wptr - rptr;
    assign fill_level = count;
    assign empty      = (wptr == rptr);
    assign full       = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign hs         = out_valid && out_ready;
    assign pop        = hs && (state == LO);
    assign drop       = sample_wr && full && !pop;
    assign push       = sample_wr && !drop;
    assign rptr_n     = rptr + {{AW{1'b0}}, pop};
    // Head as seen after this edge's pop, so the next word can be registered.
    assign head_n     = mem[rptr_n[AW-1:0]];

`ifdef TRAFFICSAMPLE_OVFL_REPORT_EN
    assign go_mark  = (overflow_cnt != 16'h0);
    assign mcnt_clr = hs && (state == MCNT);
`else
    assign go_mark  = 1'b0;
    assign mcnt_clr = 1'b0;
`endif

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: if (!empty) state_d = go_mark ? MARK : HI;
            HI:   if (hs) state_d = LO;
            LO:   if (hs) begin
                if (count > {{AW{1'b0}}, 1'b1})
                    state_d = go_mark ? MARK : HI;
                else
                    state_d = IDLE;
            end
            MARK: if (hs) state_d = MCNT;
            MCNT: if (hs) state_d = HI;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_d   = 16'h0;
        valid_d  = 1'b0;
        marker_d = 1'b0;
        unique case (state_d)
            HI: begin
                data_d  = head_n[31:16];
                valid_d = 1'b1;
            end
            LO: begin
                data_d  = head_n[15:0];
                valid_d = 1'b1;
            end
`ifdef TRAFFICSAMPLE_OVFL_REPORT_EN
            MARK: begin
                data_d   = 16'hFFFF;
                valid_d  = 1'b1;
                marker_d = 1'b1;
            end
            MCNT: begin
                data_d   = overflow_cnt;
                valid_d  = 1'b1;
                marker_d = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            wptr         <= '0;
            rptr         <= '0;
            out_data     <= 16'h0;
            out_valid    <= 1'b0;
            out_marker   <= 1'b0;
            overflow_cnt <= 16'h0;
        end else begin
            state <= state_d;
            rptr  <= rptr_n;
            if (push)
                wptr <= wptr + 1'b1;
            // Outputs only reload on a state change, so a stalled word never moves.
            if (state_d != state) begin
                out_data   <= data_d;
                out_valid  <= valid_d;
                out_marker <= marker_d;
            end
            if (mcnt_clr)
                overflow_cnt <= drop ? 16'd1 : 16'd0;
            else if (drop && overflow_cnt != 16'hFFFF)
                overflow_cnt <= overflow_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr[AW-1:0]] <= sample_data;
    end

endmodule

// File: tb/tb_trafficsample_readout.sv
// Bench for trafficsample_readout: directed cases plus random traffic
// against a queue-based word-stream model.
module tb_trafficsample_readout;

    localparam int D = 4;

    localparam logic [1:0] K_HI = 2'd0;
    localparam logic [1:0] K_LO = 2'd1;
    localparam logic [1:0] K_MK = 2'd2;
    localparam logic [1:0] K_MC = 2'd3;

    typedef struct packed {
        logic [1:0]  k;
        logic [15:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_wr = 1'b0;
    logic [31:0] sample_data = 32'h0;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_marker;
    logic [2:0]  fill_level;
    logic [15:0] overflow_cnt;

    ent_t        exp_w[$];
    int          m_fill = 0;
    logic [15:0] m_ovf = 16'h0;
    int          n_chk = 0;
    int          n_err = 0;

    trafficsample_readout #(.DEPTH(D)) dut (
        .clk(clk),
        .rst(rst),
        .sample_wr(sample_wr),
        .sample_data(sample_data),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_marker(out_marker),
        .fill_level(fill_level),
        .overflow_cnt(overflow_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One cycle: drive at negedge, check the word on offer, update the model.
    task automatic tick(input logic wr, input logic [31:0] d, input logic rdy);
        ent_t        e;
        logic        hs, pop, mclr, drop;
        logic [15:0] ovf0;
        sample_wr   = wr;
        sample_data = d;
        out_ready   = rdy;
        pop  = 1'b0;
        mclr = 1'b0;
        hs   = out_valid && rdy;
        if (out_valid) begin
            if (exp_w.size() == 0) begin
                check("spurious_valid", 32'(out_valid), 32'd0);
            end else begin
                e = exp_w[0];
                check("out_data", 32'(out_data),
                      32'((e.k == K_MC) ? m_ovf : e.d));
                check("out_marker", 32'(out_marker), 32'(e.k[1]));
            end
        end
        if (hs && exp_w.size() > 0) begin
            e = exp_w.pop_front();
            pop  = (e.k == K_LO);
            mclr = (e.k == K_MC);
        end
        ovf0 = m_ovf;
        drop = wr && (m_fill == D) && !pop;
        if (mclr)
            m_ovf = drop ? 16'd1 : 16'd0;
        else if (drop && m_ovf != 16'hFFFF)
            m_ovf = m_ovf + 16'd1;
        if (pop) begin
            m_fill--;
`ifdef TRAFFICSAMPLE_OVFL_REPORT_EN
            if (m_fill > 0 && ovf0 != 16'h0) begin
                exp_w.push_front({K_MC, 16'h0});
                exp_w.push_front({K_MK, 16'hFFFF});
            end
`endif
        end
        if (wr && !drop) begin
`ifdef TRAFFICSAMPLE_OVFL_REPORT_EN
            if (m_fill == 0 && m_ovf != 16'h0) begin
                exp_w.push_back({K_MK, 16'hFFFF});
                exp_w.push_back({K_MC, 16'h0});
            end
`endif
            exp_w.push_back({K_HI, d[31:16]});
            exp_w.push_back({K_LO, d[15:0]});
            m_fill++;
        end
        @(posedge clk);
        @(negedge clk);
        check("fill_level", 32'(fill_level), 32'(m_fill));
        check("overflow_cnt", 32'(overflow_cnt), 32'(m_ovf));
        if (ovf0 != m_ovf) ovf0 = m_ovf;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_w.size() > 0; i++)
            tick(1'b0, 32'h0, 1'b1);
        check("drain_done", exp_w.size(), 32'd0);
        tick(1'b0, 32'h0, 1'b1);
        tick(1'b0, 32'h0, 1'b1);
        check("drain_idle", 32'(out_valid), 32'd0);
    endtask

    task automatic to_lo();
        for (int i = 0; i < 20 && exp_w.size() > 0 && exp_w[0].k != K_LO; i++)
            tick(1'b0, 32'h0, 1'b1);
        check("reach_lo", 32'(exp_w.size() > 0 && exp_w[0].k == K_LO), 32'd1);
    endtask

    initial begin
        logic [15:0] ovf_before;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_marker", 32'(out_marker), 32'd0);
        check("rst_fill", 32'(fill_level), 32'd0);
        check("rst_ovf", 32'(overflow_cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // single sample latency and word order
        tick(1'b1, 32'h1234ABCD, 1'b1);
        check("lat1_valid", 32'(out_valid), 32'd0);
        tick(1'b0, 32'h0, 1'b1);
        check("lat2_valid", 32'(out_valid), 32'd1);
        check("lat2_data", 32'(out_data), 32'h1234);
        tick(1'b0, 32'h0, 1'b1);
        check("lo_data", 32'(out_data), 32'hABCD);
        tick(1'b0, 32'h0, 1'b1);
        check("single_idle", 32'(out_valid), 32'd0);

        // stall then back-to-back
        tick(1'b1, 32'h11112222, 1'b0);
        tick(1'b1, 32'h33334444, 1'b0);
        tick(1'b1, 32'h55556666, 1'b0);
        repeat (5) tick(1'b0, 32'h0, 1'b0);
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'h1111);
        for (int i = 0; i < 6; i++) begin
            check("b2b_valid", 32'(out_valid), 32'd1);
            tick(1'b0, 32'h0, 1'b1);
        end
        check("b2b_idle", 32'(out_valid), 32'd0);

        // overflow: 6 writes into 4 slots
        for (int i = 0; i < 6; i++)
            tick(1'b1, {16'hA000 + 16'(i), 16'hB000 + 16'(i)}, 1'b0);
        check("ovfl_fill", 32'(fill_level), 32'd4);
        check("ovfl_cnt", 32'(overflow_cnt), 32'd2);
        drain();
`ifdef TRAFFICSAMPLE_OVFL_REPORT_EN
        check("ovf_cleared", 32'(overflow_cnt), 32'd0);
`endif

        // write accepted on the pop cycle while full
        for (int i = 0; i < 4; i++)
            tick(1'b1, {16'hC000 + 16'(i), 16'hD000 + 16'(i)}, 1'b0);
        to_lo();
        ovf_before = overflow_cnt;
        tick(1'b1, 32'hE000F000, 1'b1);
        check("full_pop_fill", 32'(fill_level), 32'd4);
        check("full_pop_ovf", 32'(overflow_cnt), 32'(ovf_before));
        drain();

        // async reset between HI and LO words
        tick(1'b1, 32'hCAFEF00D, 1'b1);
        to_lo();
        out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_data", 32'(out_data), 32'd0);
        check("arst_fill", 32'(fill_level), 32'd0);
        check("arst_ovf", 32'(overflow_cnt), 32'd0);
        exp_w.delete();
        m_fill = 0;
        m_ovf  = 16'h0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 32'h0, 1'b1);
            check("arst_no_stale", 32'(out_valid), 32'd0);
        end

`ifndef TRAFFICSAMPLE_OVFL_REPORT_EN
        for (int i = 0; i < 3000; i++)
            tick($urandom_range(0, 99) < 40, $urandom,
                 $urandom_range(0, 99) < 60);
        drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/trafficsample_readout.md
TRAFFICSAMPLE_READOUT -- requirements
Module: trafficsample_readout

Interface
REQ-001 SHALL have parameter DEPTH, default 16: number of 32-bit sample slots; power of two, 4..256.
REQ-002 SHALL have port clk  in  1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1: reset, asynchronous and active-high.
REQ-004 SHALL have port sample_wr  in  1: one-cycle strobe; sample_data holds a window/event count to store.
REQ-005 SHALL have port sample_data  in  32: counter sample produced by the traffic monitor.
REQ-006 SHALL have port out_data  out  16: serialized sample half-word or marker word.
REQ-007 SHALL have port out_valid  out  1: out_data is valid.
REQ-008 SHALL have port out_ready  in  1: consumer accepts out_data when high with out_valid.
REQ-009 SHALL have port out_marker  out  1: high while out_data carries an overflow-marker word, not sample data.
REQ-010 SHALL have port fill_level  out  clog2(DEPTH)+1: number of samples stored, including the sample being serialized.
REQ-011 SHALL have port overflow_cnt  out  16: dropped-sample count.

Function
REQ-012 SHALL store each sample_wr sample in a DEPTH-entry FIFO in arrival order; fill_level SHALL update on the edge after the write.
REQ-013 SHALL drop a sample_wr sample when fill_level==DEPTH and no pop occurs in that cycle, and SHALL increment overflow_cnt, saturating at 16'hFFFF.
REQ-014 SHALL accept the write when FIFO is full and a pop occurs in the same cycle; fill_level stays DEPTH.
REQ-015 SHALL implement output FSM states IDLE, HI, LO (plus MARK, MCNT per REQ-025).
REQ-016 SHALL stay in IDLE with out_valid=0 while FIFO is empty; on FIFO non-empty SHALL move to HI.
REQ-017 SHALL drive out_data=head[31:16] in HI and out_data=head[15:0] in LO, with out_valid=1 in both states.
REQ-018 SHALL go HI->LO on out_valid&&out_ready.
REQ-019 SHALL pop the head on the LO handshake, then go to HI if another sample remains, else to IDLE.
REQ-020 SHALL hold out_data, out_marker and out_valid stable while out_valid&&!out_ready; no word may be withdrawn or changed.
REQ-021 SHALL register out_valid and out_data; a sample written into an empty FIFO with the FSM in IDLE SHALL raise out_valid two cycles after the sample_wr cycle.
REQ-022 SHALL emit back-to-back words at one word per cycle when out_ready is held high: 2 cycles per sample.
REQ-023 SHALL wrap FIFO read and write pointers modulo DEPTH without loss; full and empty SHALL be distinguished by the extra pointer bit.

Reset
REQ-024 SHALL, while rst is high, force FSM=IDLE, pointers=0, fill_level=0, overflow_cnt=0, out_valid=0, out_marker=0, out_data=0; a mid-transfer sample SHALL be discarded, with no resumption after reset.

Configuration
REQ-025 SHALL support macro TRAFFICSAMPLE_OVFL_REPORT_EN. When defined: on leaving IDLE or LO toward HI with overflow_cnt!=0, the FSM SHALL first visit MARK (out_data=16'hFFFF, out_marker=1), then MCNT (out_data=overflow_cnt snapshot, out_marker=1), then HI. The MCNT handshake SHALL clear overflow_cnt; a drop in that same cycle SHALL set it to 1.
REQ-026 SHALL, without TRAFFICSAMPLE_OVFL_REPORT_EN, omit MARK and MCNT, hold out_marker tied to 0, and clear overflow_cnt only on reset.

Verification
REQ-027 Single sample 32'h1234ABCD with out_ready=1 -> out_valid high 2 cycles after the write; words 16'h1234 then 16'hABCD; then IDLE.
REQ-028 Three samples with out_ready low for 5 cycles -> out_data held at the first high half; after release, 6 words in order with no gaps.
REQ-029 DEPTH=4, out_ready=0, 6 writes -> fill_level=4, overflow_cnt=2; drain yields the first 4 samples only.
REQ-030 FIFO full plus a write in the same cycle as the LO pop handshake -> write accepted, overflow_cnt unchanged, fill_level stays 4.
REQ-031 TRAFFICSAMPLE_OVFL_REPORT_EN defined, 2 drops -> FFFF/0002 with out_marker=1, then sample words; overflow_cnt=0 after MCNT.
REQ-032 rst asserted asynchronously between the HI and LO words -> out_valid=0 immediately; after release, FIFO empty and no stale words emitted.
